// File: rtl/i2c_master_ctrl.sv
// Single-transaction I2C master: START, device+R/W, memory address, one data byte, STOP.
// SCL is push-pull and SDA is open drain (sda_oe=1 pulls low); every bit slot is four quarters.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | bus idle (SCL high, SDA released), waiting for cmd_start
// START  | one slot; SDA falls while SCL is high at q2 entry
// DEV    | 8 slots, {dev, rw} MSB first
// ACK1   | slave acknowledge of the device byte
// MADDR  | 8 slots, memory address MSB first
// ACK2   | slave acknowledge of the memory address
// DATA   | 8 slots; drive write data, or release SDA and shift in read data
// ACK3   | write: slave acknowledge; read: master drives ACK low
// STOP   | one slot; SDA rises while SCL is high at q2 entry
// DONE   | one clock; pulse done, publish read data, drop busy
module i2c_master_ctrl #(
    parameter int QTR_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_start,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_maddr,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam int TW = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(QTR_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_DEV,
        S_ACK1,
        S_MADDR,
        S_ACK2,
        S_DATA,
        S_ACK3,
        S_STOP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic          rw_q, rw_d;
    logic [6:0]    dev_q, dev_d;
    logic [7:0]    maddr_q, maddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          ack_err_q, ack_err_d;
    logic          scl_q, scl_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    rdata_q, rdata_d;

    logic [1:0]    nxt_qtr;
    logic          slot_end;

    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rw_d      = rw_q;
        dev_d     = dev_q;
        maddr_d   = maddr_q;
        wdata_d   = wdata_q;
        ack_err_d = ack_err_q;
        scl_d     = scl_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rdata_d   = rdata_q;
        nxt_qtr   = qtr_q + 2'd1;
        slot_end  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_start && !busy_q) begin
                    rw_d      = cmd_rw;
                    dev_d     = cmd_dev;
                    maddr_d   = cmd_maddr;
                    wdata_d   = cmd_wdata;
                    ack_err_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_START;
                    qtr_d     = 2'd0;
                    tick_d    = TICK_MAX;
                    scl_d     = 1'b0;
                    sda_oe_d  = 1'b0;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                if (rw_q) rdata_d = rx_q;
                state_d = S_IDLE;
            end
            default: begin
                if (tick_q != '0) begin
                    tick_d = tick_q - TW'(1);
                end else begin
                    tick_d = TICK_MAX;
                    qtr_d  = nxt_qtr;
                    scl_d  = (nxt_qtr == 2'd1) || (nxt_qtr == 2'd2);
                    // q2 entry is both the START/STOP edge and the sample point (last clk of q1)
                    if (nxt_qtr == 2'd2) begin
                        case (state_q)
                            S_START: sda_oe_d = 1'b1;
                            S_STOP:  sda_oe_d = 1'b0;
                            S_ACK1, S_ACK2: if (sda_i) ack_err_d = 1'b1;
                            S_ACK3:  if (!rw_q && sda_i) ack_err_d = 1'b1;
                            S_DATA:  if (rw_q) rx_d = {rx_q[6:0], sda_i};
                            default: ;
                        endcase
                    end
                    slot_end = (nxt_qtr == 2'd0);
                end
            end
        endcase

        if (slot_end) begin
            case (state_q)
                S_START: begin
                    state_d  = S_DEV;
                    bit_d    = 3'd7;
                    tx_d     = {dev_q, rw_q};
                    sda_oe_d = ~dev_q[6];
                end
                S_DEV, S_MADDR: begin
                    if (bit_q == 3'd0) begin
                        state_d  = (state_q == S_DEV) ? S_ACK1 : S_ACK2;
                        sda_oe_d = 1'b0;
                    end else begin
                        bit_d    = bit_q - 3'd1;
                        tx_d     = {tx_q[6:0], 1'b0};
                        sda_oe_d = ~tx_q[6];
                    end
                end
                S_ACK1: begin
                    if (ack_err_q) begin
                        state_d  = S_STOP;
                        sda_oe_d = 1'b1;
                    end else begin
                        state_d  = S_MADDR;
                        bit_d    = 3'd7;
                        tx_d     = maddr_q;
                        sda_oe_d = ~maddr_q[7];
                    end
                end
                S_ACK2: begin
                    if (ack_err_q) begin
                        state_d  = S_STOP;
                        sda_oe_d = 1'b1;
                    end else begin
                        state_d  = S_DATA;
                        bit_d    = 3'd7;
                        tx_d     = wdata_q;
                        sda_oe_d = !rw_q && !wdata_q[7];
                    end
                end
                S_DATA: begin
                    if (bit_q == 3'd0) begin
                        state_d  = S_ACK3;
                        sda_oe_d = rw_q;
                    end else begin
                        bit_d    = bit_q - 3'd1;
                        tx_d     = {tx_q[6:0], 1'b0};
                        sda_oe_d = !rw_q && !tx_q[6];
                    end
                end
                S_ACK3: begin
                    state_d  = S_STOP;
                    sda_oe_d = 1'b1;
                end
                S_STOP: begin
                    // Park SCL high so the bus is idle again once the frame is over
                    state_d  = S_DONE;
                    scl_d    = 1'b1;
                    sda_oe_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            qtr_q     <= 2'd0;
            tick_q    <= '0;
            bit_q     <= 3'd0;
            tx_q      <= 8'h00;
            rx_q      <= 8'h00;
            rw_q      <= 1'b0;
            dev_q     <= 7'h00;
            maddr_q   <= 8'h00;
            wdata_q   <= 8'h00;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            qtr_q     <= qtr_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rw_q      <= rw_d;
            dev_q     <= dev_d;
            maddr_q   <= maddr_d;
            wdata_q   <= wdata_d;
            ack_err_q <= ack_err_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign scl     = scl_q;
    assign sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: behavioural I2C slave (id 1, 256-byte memory), bus protocol
// checker, command vector table with a done-time scoreboard, plus mid-frame corner sequences.
`timescale 1ns/1ps
module tb_i2c_master_ctrl;

    localparam int Q = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_start = 1'b0;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_dev = 7'h00;
    logic [7:0] cmd_maddr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic [7:0] rdata;
    logic       busy, done, ack_err, scl, sda_oe;
    logic       slave_pull = 1'b0;
    wire        sda_w = ~(sda_oe | slave_pull);

    i2c_master_ctrl #(.QTR_CYCLES(Q)) dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_rw(cmd_rw),
        .cmd_dev(cmd_dev), .cmd_maddr(cmd_maddr), .cmd_wdata(cmd_wdata),
        .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err),
        .scl(scl), .sda_oe(sda_oe), .sda_i(sda_w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- slave model and protocol checker ----------------
    logic [7:0] mem [0:255];
    int         cnt = 0;
    bit         in_frame = 1'b0;
    bit         matched = 1'b0;
    bit         maddr_ok = 1'b0;
    logic [7:0] dev_sh = 8'h00, maddr_sh = 8'h00, data_sh = 8'h00, last_dev = 8'h00, rd_byte;
    logic       m_ack = 1'b1;
    int         n_start = 0, n_stop = 0, n_viol = 0;

    always @(sda_w) begin
        if (reset === 1'b1 && scl === 1'b1) begin
            if (sda_w === 1'b0 && !in_frame) begin
                in_frame = 1'b1; cnt = 0; matched = 1'b0; maddr_ok = 1'b0; m_ack = 1'b1;
                n_start++;
            end else if (sda_w === 1'b1 && in_frame && (cnt == 10 || cnt == 19 || cnt == 28)) begin
                in_frame = 1'b0;
                n_stop++;
            end else begin
                n_viol++;
                $display("FAIL protocol: SDA moved to %b with SCL high at %0t (bit %0d)", sda_w, $time, cnt);
            end
        end
    end

    always @(posedge scl) begin
        if (reset === 1'b1 && in_frame) begin
            cnt++;
            if (cnt <= 8) dev_sh = {dev_sh[6:0], sda_w};
            else if (cnt >= 10 && cnt <= 17) maddr_sh = {maddr_sh[6:0], sda_w};
            else if (cnt >= 19 && cnt <= 26) data_sh = {data_sh[6:0], sda_w};
            if (cnt == 26 && matched && maddr_ok && !dev_sh[0]) mem[maddr_sh] = data_sh;
            if (cnt == 27) m_ack = sda_w;
        end
    end

    always @(negedge scl) begin
        if (reset === 1'b1 && in_frame) begin
            slave_pull = 1'b0;
            if (cnt == 8) begin
                matched = (dev_sh[7:1] == 7'h01);
                last_dev = dev_sh;
                slave_pull = matched;
            end else if (cnt == 17) begin
                maddr_ok = (maddr_sh[7:4] != 4'hF);
                slave_pull = matched && maddr_ok;
            end else if (cnt >= 18 && cnt <= 25 && matched && maddr_ok && dev_sh[0]) begin
                rd_byte = mem[maddr_sh];
                slave_pull = ~rd_byte[25 - cnt];
            end else if (cnt == 26 && matched && maddr_ok && !dev_sh[0]) begin
                slave_pull = 1'b1;
            end
        end
    end

    always @(negedge reset) begin
        in_frame = 1'b0;
        slave_pull = 1'b0;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] rdata;
        logic       err;
        bit         chk_rd;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always @(posedge clk) begin
        #1;
        if (reset === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected_done: done with no pending command at %0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.name, "_ack_err"}, ack_err, mon_e.err);
                if (mon_e.chk_rd) chk({mon_e.name, "_rdata"}, rdata, mon_e.rdata);
                chk({mon_e.name, "_busy_at_done"}, busy, 1'b0);
            end
        end
    end

    task automatic run_cmd(input string name, input logic rw, input logic [6:0] dev,
                           input logic [7:0] maddr, input logic [7:0] wdata,
                           input logic [7:0] exp_rd, input logic exp_err,
                           input int nack, input int spoil_at);
        exp_t e;
        int n, exp_lat, s0, p0, diffs;
        bit got, wr_ok;
        logic [7:0] snap [0:255];
        snap = mem;
        s0 = n_start;
        p0 = n_stop;
        exp_lat = (nack == 1) ? 44*Q + 1 : (nack == 2) ? 80*Q + 1 : 116*Q + 1;
        wr_ok = !rw && (nack == 0) && !exp_err;
        e.rdata = exp_rd; e.err = exp_err; e.chk_rd = !(rw && nack != 0); e.name = name;
        sb_q.push_back(e);
        cmd_rw = rw; cmd_dev = dev; cmd_maddr = maddr; cmd_wdata = wdata; cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        chk({name, "_busy_after_accept"}, busy, 1'b1);
        n = 0; got = 1'b0;
        while (!got && n < 4000) begin
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) got = 1'b1;
            else if (spoil_at > 0 && n == spoil_at) begin
                cmd_rw = ~rw; cmd_dev = 7'h03; cmd_maddr = 8'h55; cmd_wdata = ~wdata;
                cmd_start = 1'b1;
            end else cmd_start = 1'b0;
        end
        cmd_start = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no done after %0d clk, expected %0d", name, n, exp_lat);
        end else begin
            chk({name, "_latency"}, n, exp_lat);
            @(posedge clk); #1;
            chk({name, "_done_one_cycle"}, done, 1'b0);
        end
        chk({name, "_starts"}, n_start - s0, 1);
        chk({name, "_stops"}, n_stop - p0, 1);
        chk({name, "_dev_byte"}, last_dev, {dev, rw});
        diffs = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== snap[i] && !(wr_ok && i == int'(maddr))) diffs++;
        chk({name, "_mem_untouched"}, diffs, 0);
        if (wr_ok) chk({name, "_mem_written"}, mem[maddr], wdata);
        if (rw && nack == 0) chk({name, "_master_ack"}, m_ack, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rw;
        logic [6:0] dev;
        logic [7:0] maddr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic       exp_err;
        int         nack;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 7'h01, 8'h02, 8'h7F, 8'h00, 1'b0, 0};
        vecs[1]  = '{1'b1, 7'h01, 8'h01, 8'hC3, 8'h05, 1'b0, 0};
        vecs[2]  = '{1'b1, 7'h01, 8'h02, 8'hC3, 8'h7F, 1'b0, 0};
        vecs[3]  = '{1'b0, 7'h03, 8'h05, 8'hAA, 8'h7F, 1'b1, 1};
        vecs[4]  = '{1'b0, 7'h01, 8'hF3, 8'h11, 8'h7F, 1'b1, 2};
        vecs[5]  = '{1'b0, 7'h01, 8'h10, 8'hA5, 8'h7F, 1'b0, 0};
        vecs[6]  = '{1'b1, 7'h01, 8'h10, 8'h00, 8'hA5, 1'b0, 0};
        vecs[7]  = '{1'b0, 7'h01, 8'h00, 8'h00, 8'hA5, 1'b0, 0};
        vecs[8]  = '{1'b1, 7'h01, 8'h00, 8'hFF, 8'h00, 1'b0, 0};
        vecs[9]  = '{1'b0, 7'h01, 8'h7F, 8'hFF, 8'h00, 1'b0, 0};
        vecs[10] = '{1'b1, 7'h01, 8'h7F, 8'h00, 8'hFF, 1'b0, 0};
        vecs[11] = '{1'b0, 7'h7F, 8'h20, 8'h5A, 8'hFF, 1'b1, 1};

        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[1] = 8'h05;

        #2 reset = 1'b0;
        #20;
        chk("reset_scl", scl, 1'b1);
        chk("reset_sda_oe", sda_oe, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_ack_err", ack_err, 1'b0);
        chk("reset_rdata", rdata, 8'h00);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++)
            run_cmd($sformatf("v%0d", i), vecs[i].rw, vecs[i].dev, vecs[i].maddr, vecs[i].wdata,
                    vecs[i].exp_rd, vecs[i].exp_err, vecs[i].nack, 0);

        // Competing strobe during DEV must not disturb the frame in flight
        run_cmd("spoil", 1'b0, 7'h01, 8'h20, 8'h3C, 8'hFF, 1'b0, 0, 50);

        // Reset in the middle of a write DATA phase
        cmd_rw = 1'b0; cmd_dev = 7'h01; cmd_maddr = 8'h30; cmd_wdata = 8'h99; cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        repeat (19*4*Q + 10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midreset_scl", scl, 1'b1);
        chk("midreset_sda_oe", sda_oe, 1'b0);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_done", done, 1'b0);
        chk("midreset_rdata", rdata, 8'h00);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset_mem30", mem[8'h30], 8'h6A);
        run_cmd("post_wr", 1'b0, 7'h01, 8'h31, 8'h42, 8'h00, 1'b0, 0, 0);
        run_cmd("post_rd", 1'b1, 7'h01, 8'h31, 8'h00, 8'h42, 1'b0, 0, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("protocol_violations", n_viol, 0);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
